reg_file_sb: RTL

//  Parametrised register file for the pipelined beta core: NRD read ports, NBYP-stage bypass network, async clear.

---
 rtl/reg_file_sb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with bypass network and load-pending scoreboard.
// Ports: ra/ra_need/rd read ports, byp_* bypass stages, we/wa/wd/wb_load write port,
//   dec_* decode info, issue, stall request, pending scoreboard, stall_cnt counter.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NBYP     = 3,
  parameter int ZERO_REG = 31,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD*AW-1:0]      ra,
  input  logic [NRD-1:0]         ra_need,
  output logic [NRD*DATA_W-1:0]  rd,
  input  logic                   dec_wr,
  input  logic [AW-1:0]          dec_rc,
  input  logic                   dec_load,
  input  logic                   issue,
  input  logic [NBYP-1:0]        byp_valid,
  input  logic [NBYP*AW-1:0]     byp_addr,
  input  logic [NBYP-1:0]        byp_ready,
  input  logic [NBYP*DATA_W-1:0] byp_data,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [DATA_W-1:0]      wd,
  input  logic                   wb_load,
  output logic                   stall,
  output logic [NREGS-1:0]       pending,
  output logic [31:0]            stall_cnt
);

  // Storage covers every encodable address; slots at or above NREGS are
  // never written, so they read back as zero and never go pending.
  localparam int NSLOT = 1 << AW;
  localparam logic [NSLOT-1:0] VMASK =
    {NSLOT{1'b1}} >> (NSLOT - NREGS);
  localparam logic [AW-1:0] ZR = ZERO_REG[AW-1:0];

  logic [DATA_W-1:0] regs_q [NSLOT];
  logic [NSLOT-1:0]  pend_q;
  logic [NSLOT-1:0]  pend_d;
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;
  logic [NRD-1:0]    haz;
  logic              waw;
  logic              ld_clr;

  assign ld_clr = we && wb_load;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] v;
      logic              hit;
      logic              bh;

      assign a = ra[gi*AW +: AW];

      always_comb begin
        v   = '0;
        hit = 1'b0;
        bh  = 1'b0;
        if (a != ZR) begin
          // Youngest matching stage wins; older stages are masked by hit.
          for (int j = 0; j < NBYP; j++) begin
            if (!hit && byp_valid[j] &&
                byp_addr[j*AW +: AW] == a) begin
              hit = 1'b1;
              if (byp_ready[j]) begin
                v = byp_data[j*DATA_W +: DATA_W];
              end else begin
                bh = 1'b1;
              end
            end
          end
          if (!hit) begin
            if (we && wa == a) begin
              v = wd;
            end else begin
              v = regs_q[a];
            end
            // A load landing this cycle resolves its own pending bit.
            if (pend_q[a] && !(ld_clr && wa == a)) begin
              bh = 1'b1;
            end
          end
        end
      end

      assign rd[gi*DATA_W +: DATA_W] = v;
      assign haz[gi] = ra_need[gi] && bh;
    end
  endgenerate

  assign waw = dec_wr && (dec_rc != ZR) && pend_q[dec_rc] &&
               !(ld_clr && wa == dec_rc);

  assign stall     = (|haz) || waw;
  assign pending   = pend_q[NREGS-1:0];
  assign stall_cnt = cnt_q;

  always_comb begin
    pend_d = pend_q;
    if (ld_clr && VMASK[wa]) begin
      pend_d[wa] = 1'b0;
    end
    // Set after clear so a same-register set wins.
    if (issue && !stall && dec_wr && dec_load &&
        dec_rc != ZR && VMASK[dec_rc]) begin
      pend_d[dec_rc] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) begin
        regs_q[k] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we && wa != ZR && VMASK[wa]) begin
        regs_q[wa] <= wd;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
